ssd_display_arb: RTL and testbench

- Time-shares the single four-digit seven-segment controller between NUM_REQ independent requesters, such as a status counter, an error code and a debug value.
- Each requester raises req and presents 16-bit hex data, a digit-enable mask and a decimal-point mask.
- The arbiter grants the display round-robin for a fixed dwell time and drives the controller's data, digit-enable and point inputs from the granted requester.
- Sits between the application logic and the seven-segment controller in the top level.

---
 rtl/ssd_arb_pkg.sv | 14 +
 rtl/ssd_rr_pick.sv | 35 +++
 rtl/ssd_display_arb.sv | 174 +++++++++++++++++
 tb/tb_ssd_display_arb.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package ssd_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam logic [15:0] BLANK_DATA  = 16'h0000;
    localparam logic [3:0]  BLANK_DIG   = 4'b0000;
    localparam logic [3:0]  BLANK_POINT = 4'b0000;
    localparam int          BLINK_BITS  = 24;

endpackage

// File: rtl/ssd_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after start, wrapping modulo NUM_REQ.
module ssd_rr_pick
    import ssd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   index,
    output logic [NUM_REQ-1:0] onehot
);

    logic [IDX_W-1:0] pos_s;

    // Walk the ring from the far end back to start so the nearest hit is written last.
    always_comb begin
        found  = 1'b0;
        index  = '0;
        onehot = '0;
        pos_s  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos_s = IDX_W'((int'(start) + k) % NUM_REQ);
            if (req[pos_s]) begin
                found  = 1'b1;
                index  = pos_s;
                onehot = NUM_REQ'(1) << pos_s;
            end else begin
                found  = found;
            end
        end
    end

endmodule

// File: rtl/ssd_display_arb.sv
// Round-robin time-sharing of one four-digit seven-segment controller between NUM_REQ requesters.
// Optional blink gating of the digit enables is built when SSD_ARB_BLINK_EN is defined.
module ssd_display_arb
    import ssd_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_data,
    input  logic [4*NUM_REQ-1:0]   req_dig,
    input  logic [4*NUM_REQ-1:0]   req_point,
`ifdef SSD_ARB_BLINK_EN
    input  logic [NUM_REQ-1:0]     req_blink,
`endif
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [15:0]            disp_data,
    output logic [3:0]             disp_dig,
    output logic [3:0]             disp_point,
    output logic                   busy
);

    localparam int               IDX_W      = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    arb_state_t         state_r, state_n;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_n;
    logic [IDX_W-1:0]   owner_r, owner_n;
    logic [CNT_W-1:0]   cnt_r, cnt_n;
    logic [NUM_REQ-1:0] grant_r, grant_n;
    logic [NUM_REQ-1:0] done_r, done_n;
    logic [15:0]        data_r, data_n;
    logic [3:0]         dig_r, dig_n;
    logic [3:0]         point_r, point_n;
    logic               busy_r;

    logic               owner_req_s, timeout_s, release_s, slot_end_s, blank_dig_s;
    logic [IDX_W-1:0]   next_ptr_s, pick_start_s, pick_idx_s;
    logic               pick_found_s;
    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [15:0]        sel_data_s;
    logic [3:0]         sel_dig_s, sel_point_s;

    assign owner_req_s  = req[owner_r];
    assign timeout_s    = (state_r == OWN) && owner_req_s && (cnt_r == '0);
    assign release_s    = (state_r == OWN) && !owner_req_s;
    assign slot_end_s   = timeout_s || release_s;
    assign next_ptr_s   = (owner_r == IDX_W'(NUM_REQ - 1)) ? '0 : owner_r + IDX_W'(1);
    // At a slot end the search starts just past the grantee, so it is considered last.
    assign pick_start_s = (state_r == OWN) ? next_ptr_s : rr_ptr_r;
    assign sel_data_s   = req_data[{owner_r, 4'b0000} +: 16];
    assign sel_dig_s    = req_dig[{owner_r, 2'b00} +: 4];
    assign sel_point_s  = req_point[{owner_r, 2'b00} +: 4];

`ifdef SSD_ARB_BLINK_EN
    logic [BLINK_BITS-1:0] blink_cnt_r;
    logic [BLINK_BITS-1:0] blink_nxt_s;

    assign blink_nxt_s = blink_cnt_r + BLINK_BITS'(1);
    assign blank_dig_s = req_blink[owner_r] && blink_nxt_s[BLINK_BITS-1];

    // Free-running blink phase counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_r <= '0;
        end else begin
            blink_cnt_r <= blink_nxt_s;
        end
    end
`else
    assign blank_dig_s = 1'b0;
`endif

    ssd_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .start  (pick_start_s),
        .found  (pick_found_s),
        .index  (pick_idx_s),
        .onehot (pick_onehot_s)
    );

    // Next-state and next-output decode for the IDLE/OWN arbiter.
    always_comb begin
        state_n  = state_r;
        rr_ptr_n = rr_ptr_r;
        owner_n  = owner_r;
        cnt_n    = cnt_r;
        grant_n  = grant_r;
        done_n   = '0;
        data_n   = BLANK_DATA;
        dig_n    = BLANK_DIG;
        point_n  = BLANK_POINT;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_n = OWN;
                    owner_n = pick_idx_s;
                    grant_n = pick_onehot_s;
                    cnt_n   = DWELL_LOAD;
                end else begin
                    grant_n = '0;
                end
            end
            OWN: begin
                data_n  = sel_data_s;
                dig_n   = blank_dig_s ? BLANK_DIG : sel_dig_s;
                point_n = sel_point_s;
                if (slot_end_s) begin
                    rr_ptr_n = next_ptr_s;
                    done_n   = timeout_s ? grant_r : '0;
                    if (pick_found_s) begin
                        owner_n = pick_idx_s;
                        grant_n = pick_onehot_s;
                        cnt_n   = DWELL_LOAD;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        data_n  = BLANK_DATA;
                        dig_n   = BLANK_DIG;
                        point_n = BLANK_POINT;
                    end
                end else begin
                    cnt_n = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            owner_r  <= '0;
            cnt_r    <= '0;
            grant_r  <= '0;
            done_r   <= '0;
            data_r   <= BLANK_DATA;
            dig_r    <= BLANK_DIG;
            point_r  <= BLANK_POINT;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            rr_ptr_r <= rr_ptr_n;
            owner_r  <= owner_n;
            cnt_r    <= cnt_n;
            grant_r  <= grant_n;
            done_r   <= done_n;
            data_r   <= data_n;
            dig_r    <= dig_n;
            point_r  <= point_n;
            busy_r   <= (state_n == OWN);
        end
    end

    assign grant      = grant_r;
    assign done       = done_r;
    assign disp_data  = data_r;
    assign disp_dig   = dig_r;
    assign disp_point = point_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_ssd_display_arb.sv
// Scoreboard bench for ssd_display_arb (NUM_REQ=3, DWELL_CYCLES=8); blink test only with SSD_ARB_BLINK_EN.
module tb_ssd_display_arb;

    localparam int NR = 3;
    localparam int DW = 8;

    logic          clk;
    logic          reset_v;
    logic [NR-1:0] req_v;
    logic [47:0]   data_v;
    logic [11:0]   dig_v;
    logic [11:0]   point_v;
    logic [NR-1:0] grant, done;
    logic [15:0]   disp_data;
    logic [3:0]    disp_dig, disp_point;
    logic          busy;
`ifdef SSD_ARB_BLINK_EN
    logic [NR-1:0] blink_v;
`endif

    int checks;
    int failures;

    // Reference model state (spec-level: remaining-cycle count per slot).
    bit          m_own;
    int          m_ptr, m_owner, m_left;
    logic [NR-1:0] m_grant, m_done;
    logic [15:0] m_data;
    logic [3:0]  m_dig, m_point;
    logic [30:0] sb_q[$];

    ssd_display_arb #(.NUM_REQ(NR), .DWELL_CYCLES(DW)) dut (
        .clk        (clk),
        .reset      (reset_v),
        .req        (req_v),
        .req_data   (data_v),
        .req_dig    (dig_v),
        .req_point  (point_v),
`ifdef SSD_ARB_BLINK_EN
        .req_blink  (blink_v),
`endif
        .grant      (grant),
        .done       (done),
        .disp_data  (disp_data),
        .disp_dig   (disp_dig),
        .disp_point (disp_point),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic grant_first(input int start);
        for (int j = 0; j < NR; j++) begin
            int idx;
            idx = (start + j) % NR;
            if (req_v[idx] && !m_own) begin
                m_own   = 1'b1;
                m_owner = idx;
                m_grant = '0;
                m_grant[idx] = 1'b1;
                m_left  = DW;
            end
        end
    endtask

    task automatic model_step();
        if (reset_v) begin
            m_own = 1'b0; m_ptr = 0; m_owner = 0; m_left = 0;
            m_grant = '0; m_done = '0; m_data = '0; m_dig = '0; m_point = '0;
        end else if (!m_own) begin
            m_done = '0; m_data = '0; m_dig = '0; m_point = '0;
            m_grant = '0;
            grant_first(m_ptr);
        end else begin
            m_done  = '0;
            m_data  = data_v[16*m_owner +: 16];
            m_dig   = dig_v[4*m_owner +: 4];
            m_point = point_v[4*m_owner +: 4];
            if (!req_v[m_owner] || m_left == 1) begin
                if (req_v[m_owner]) m_done = m_grant;
                m_ptr   = (m_owner + 1) % NR;
                m_own   = 1'b0;
                m_grant = '0;
                grant_first(m_ptr);
                if (!m_own) begin
                    m_data = '0; m_dig = '0; m_point = '0;
                end
            end else begin
                m_left--;
            end
        end
    endtask

    // Push the model's expectation for the coming edge, then advance one clock.
    task automatic step();
        model_step();
        sb_q.push_back({m_grant, m_done, m_data, m_dig, m_point, m_own});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [30:0] observed();
        return {grant, done, disp_data, disp_dig, disp_point, busy};
    endfunction

    task automatic test_reset();
        logic [30:0] exp;
        reset_v = 1'b1;
        req_v   = 3'b111;
        for (int c = 0; c < 3; c++) begin
            step();
            exp = sb_q.pop_front();
            checks++;
            if (observed() !== exp) begin
                failures++;
                $display("FAIL reset_sb cyc=%0d got=%h exp=%h", c, observed(), exp);
            end
        end
        checks++;
        if ({grant, disp_dig, busy} !== 8'h00) begin
            failures++;
            $display("FAIL reset_vals got grant=%b dig=%b busy=%b exp 0", grant, disp_dig, busy);
        end
        reset_v = 1'b0;
        step();
        exp = sb_q.pop_front();
        checks++;
        if (grant !== 3'b001 || observed() !== exp) begin
            failures++;
            $display("FAIL reset_first_grant got=%b exp=001", grant);
        end
        step();
        exp = sb_q.pop_front();
        checks++;
        if (disp_data !== 16'h1234 || observed() !== exp) begin
            failures++;
            $display("FAIL reset_first_data got=%h exp=1234", disp_data);
        end
    endtask

    task automatic test_round_robin();
        logic [30:0] exp;
        int dones, zero_grants;
        dones = 0;
        zero_grants = 0;
        req_v = 3'b111;
        for (int c = 1; c <= 32; c++) begin
            step();
            exp = sb_q.pop_front();
            checks++;
            if (observed() !== exp) begin
                failures++;
                $display("FAIL rr_sb cyc=%0d got=%h exp=%h", c, observed(), exp);
            end
            if (done != '0) dones++;
            if (grant == '0) zero_grants++;
        end
        checks++;
        if (dones !== 4 || zero_grants !== 0) begin
            failures++;
            $display("FAIL rr_summary got dones=%0d bubbles=%0d exp dones=4 bubbles=0", dones, zero_grants);
        end
    endtask

    task automatic test_sole_requester();
        logic [30:0] exp;
        int dones, off;
        dones = 0;
        off = 0;
        req_v = 3'b010;
        data_v[31:16] = 16'hBEEF;
        dig_v[7:4] = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            step();
            exp = sb_q.pop_front();
            checks++;
            if (observed() !== exp) begin
                failures++;
                $display("FAIL sole_sb cyc=%0d got=%h exp=%h", c, observed(), exp);
            end
            if (c >= 24) begin
                if (done[1]) dones++;
                if (grant !== 3'b010) off++;
            end
        end
        checks++;
        if (dones !== 2 || off !== 0 || disp_data !== 16'hBEEF) begin
            failures++;
            $display("FAIL sole_summary got dones=%0d off=%0d data=%h exp 2 0 beef", dones, off, disp_data);
        end
    endtask

    task automatic test_early_release();
        logic [30:0] exp;
        int done0;
        done0 = 0;
        reset_v = 1'b1;
        step();
        void'(sb_q.pop_front());
        reset_v = 1'b0;
        req_v = 3'b001;
        for (int c = 0; c < 3; c++) begin
            step();
            exp = sb_q.pop_front();
            checks++;
            if (observed() !== exp) begin
                failures++;
                $display("FAIL rel_sb cyc=%0d got=%h exp=%h", c, observed(), exp);
            end
            if (done[0]) done0++;
        end
        req_v = 3'b100;
        step();
        exp = sb_q.pop_front();
        if (done[0]) done0++;
        checks++;
        if (grant !== 3'b100 || observed() !== exp) begin
            failures++;
            $display("FAIL rel_handover got=%b exp=100", grant);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            exp = sb_q.pop_front();
            checks++;
            if (observed() !== exp) begin
                failures++;
                $display("FAIL rel_sb2 cyc=%0d got=%h exp=%h", c, observed(), exp);
            end
            if (done[0]) done0++;
        end
        req_v = 3'b000;
        step();
        exp = sb_q.pop_front();
        checks++;
        if (grant !== 3'b000 || disp_dig !== 4'b0000 || disp_data !== 16'h0000 || done !== 3'b000
            || observed() !== exp) begin
            failures++;
            $display("FAIL rel_blank got grant=%b dig=%b data=%h done=%b exp 000 0000 0000 000",
                     grant, disp_dig, disp_data, done);
        end
        checks++;
        if (done0 !== 0) begin
            failures++;
            $display("FAIL rel_no_done0 got=%0d exp=0", done0);
        end
    endtask

    task automatic test_reset_mid_slot();
        logic [30:0] exp;
        req_v = 3'b111;
        for (int c = 0; c < 12; c++) begin
            step();
            exp = sb_q.pop_front();
            checks++;
            if (observed() !== exp) begin
                failures++;
                $display("FAIL mid_sb cyc=%0d got=%h exp=%h", c, observed(), exp);
            end
        end
        checks++;
        if (grant !== 3'b010) begin
            failures++;
            $display("FAIL mid_pre got=%b exp=010", grant);
        end
        reset_v = 1'b1;
        step();
        exp = sb_q.pop_front();
        checks++;
        if (observed() !== 31'h0 || observed() !== exp) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=0", observed());
        end
        reset_v = 1'b0;
        step();
        exp = sb_q.pop_front();
        checks++;
        if (grant !== 3'b001 || observed() !== exp) begin
            failures++;
            $display("FAIL mid_restart got=%b exp=001", grant);
        end
    endtask

`ifdef SSD_ARB_BLINK_EN
    task automatic test_blink();
        reset_v = 1'b1;
        req_v = 3'b001;
        blink_v = 3'b001;
        @(posedge clk); #1;
        reset_v = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (disp_dig !== 4'b1111) begin
            failures++;
            $display("FAIL blink_pre got=%b exp=1111", disp_dig);
        end
        force dut.blink_cnt_r = 24'h7FFFFF;
        @(posedge clk); #1;
        release dut.blink_cnt_r;
        checks++;
        if (disp_dig !== 4'b0000 || disp_data !== 16'h1234) begin
            failures++;
            $display("FAIL blink_off got dig=%b data=%h exp 0000 1234", disp_dig, disp_data);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset_v  = 1'b1;
        req_v    = '0;
        data_v   = {16'hCAFE, 16'h5A5A, 16'h1234};
        dig_v    = {4'b0111, 4'b0011, 4'b1111};
        point_v  = {4'b0100, 4'b0010, 4'b0001};
`ifdef SSD_ARB_BLINK_EN
        blink_v  = '0;
`endif
        #1;
        test_reset();
        test_round_robin();
        test_sole_requester();
        test_early_release();
        test_reset_mid_slot();
`ifdef SSD_ARB_BLINK_EN
        test_blink();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
